// File: rtl/bt_air_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt_air_pkg
// Description : Shared constants and helpers for the bt_air_chan channel
//               model: default hop-frequency width, bit-error LFSR seed and
//               Galois tap mask, LFSR step and 16-bit rotate-left.
// Revision    : 1.0 - initial release
// ============================================================================
package bt_air_pkg;

  localparam int          FKW_DEF   = 7;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Rotate left by n mod 16; gives each port its own view of one LFSR so
  // the ports do not flip bits in lock-step.
  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
    int unsigned s;
    s = n % 16;
    return (v << s) | (v >> (16 - s));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bt_air_pll.sv
`default_nettype none
// ============================================================================
// Module      : bt_air_pll
// Description : Per-port synthesiser model. Latches the next hop frequency on
//               a load strobe and holds 'locked' low for SETTLE cycles.
// Ports       : clk_6M  - 6 MHz clock
//               rstz    - asynchronous active-low reset
//               load    - one-cycle frequency-load strobe
//               fk_in   - frequency to load
//               fk      - currently tuned frequency
//               locked  - synthesiser settled
// Revision    : 1.0 - initial release
// ============================================================================
module bt_air_pll
  import bt_air_pkg::*;
#(
  parameter int FKW    = FKW_DEF,
  parameter int SETTLE = 900
) (
  input  logic           clk_6M,
  input  logic           rstz,
  input  logic           load,
  input  logic [FKW-1:0] fk_in,
  output logic [FKW-1:0] fk,
  output logic           locked
);

  localparam int            CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  logic [CW-1:0] cnt;

  // A load on the cycle the count would expire takes priority, so the
  // port never reports lock on a frequency it is about to leave.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      fk     <= '0;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (load) begin
      fk     <= fk_in;
      cnt    <= SETTLE_C;
      locked <= (SETTLE == 0);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        locked <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bt_air_chan.sv
`default_nettype none
// ============================================================================
// Module      : bt_air_chan
// Description : N-port air channel: per-port synthesiser settling, frequency
//               matched bit routing with collision detection, LAT-stage rx
//               pipeline and LFSR-driven bit-error injection.
// Ports       : clk_6M, rstz          - clock, async active-low reset
//               txen/rxen/txbitin     - per-port tx enable, rx enable, tx bit
//               lc_fk, loadfreq_p     - per-port next frequency and load strobe
//               err_inj_en/err_thresh - error injection enable, flip threshold
//               rxbitout/rxvalid      - per-port received bit and its validity
//               collision             - >=2 transmitters on this port's channel
//               cur_fk/locked         - tuned frequency and settle status
// Revision    : 1.0 - initial release
// ============================================================================
module bt_air_chan
  import bt_air_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int FKW    = FKW_DEF,
  parameter int LAT    = 3,
  parameter int SETTLE = 900
) (
  input  logic                 clk_6M,
  input  logic                 rstz,
  input  logic [NPORT-1:0]     txen,
  input  logic [NPORT-1:0]     rxen,
  input  logic [NPORT-1:0]     txbitin,
  input  logic [NPORT*FKW-1:0] lc_fk,
  input  logic [NPORT-1:0]     loadfreq_p,
  input  logic                 err_inj_en,
  input  logic [15:0]          err_thresh,
  output logic [NPORT-1:0]     rxbitout,
  output logic [NPORT-1:0]     rxvalid,
  output logic [NPORT-1:0]     collision,
  output logic [NPORT*FKW-1:0] cur_fk,
  output logic [NPORT-1:0]     locked
);

  for (genvar i = 0; i < NPORT; i++) begin : g_pll
    bt_air_pll #(
      .FKW    (FKW),
      .SETTLE (SETTLE)
    ) u_pll (
      .clk_6M (clk_6M),
      .rstz   (rstz),
      .load   (loadfreq_p[i]),
      .fk_in  (lc_fk[i*FKW +: FKW]),
      .fk     (cur_fk[i*FKW +: FKW]),
      .locked (locked[i])
    );
  end

  logic [NPORT-1:0] act;
  logic [NPORT-1:0] heard [NPORT];
  logic [NPORT-1:0] s0_bit, s0_valid, s0_coll;

  assign act = txen & locked;

  always_comb begin
    s0_bit   = '0;
    s0_valid = '0;
    s0_coll  = '0;
    for (int i = 0; i < NPORT; i++) begin
      heard[i] = '0;
      for (int j = 0; j < NPORT; j++) begin
        if (j != i && act[j] && cur_fk[j*FKW +: FKW] == cur_fk[i*FKW +: FKW]) begin
          heard[i][j] = 1'b1;
        end
      end
      // Half duplex: a transmitting port never hears anything, itself included.
      if (rxen[i] && locked[i] && !txen[i]) begin
        if ($countones(heard[i]) == 1) begin
          s0_bit[i]   = |(heard[i] & txbitin);
          s0_valid[i] = 1'b1;
        end else if ($countones(heard[i]) >= 2) begin
          s0_coll[i]  = 1'b1;
        end
      end
    end
  end

  logic [NPORT-1:0] pb [LAT];
  logic [NPORT-1:0] pv [LAT];
  logic [NPORT-1:0] pc [LAT];
  logic [15:0]      lfsr;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      for (int k = 0; k < LAT; k++) begin
        pb[k] <= '0;
        pv[k] <= '0;
        pc[k] <= '0;
      end
      lfsr <= LFSR_SEED;
    end else begin
      pb[0] <= s0_bit;
      pv[0] <= s0_valid;
      pc[0] <= s0_coll;
      for (int k = 1; k < LAT; k++) begin
        pb[k] <= pb[k-1];
        pv[k] <= pv[k-1];
        pc[k] <= pc[k-1];
      end
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Flips are decided at the pipeline exit and only ever touch valid bits.
  logic [NPORT-1:0] flip;

  always_comb begin
    flip = '0;
    for (int i = 0; i < NPORT; i++) begin
      flip[i] = err_inj_en & pv[LAT-1][i] & (rotl16(lfsr, unsigned'(i)) < err_thresh);
    end
  end

  assign rxbitout  = pb[LAT-1] ^ flip;
  assign rxvalid   = pv[LAT-1];
  assign collision = pc[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_bt_air_chan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_air_chan
// Description : Self-checking bench for bt_air_chan (NPORT=4, FKW=7, LAT=3,
//               SETTLE=900): reset, lock timing, routing vector table,
//               streaming latency, collision recovery and error injection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_air_chan;

  localparam int NPORT  = 4;
  localparam int FKW    = 7;
  localparam int LAT    = 3;
  localparam int SETTLE = 900;

  logic                 clk_6M = 1'b0;
  logic                 rstz   = 1'b0;
  logic [NPORT-1:0]     txen, rxen, txbitin, loadfreq_p;
  logic [NPORT*FKW-1:0] lc_fk;
  logic                 err_inj_en;
  logic [15:0]          err_thresh;
  logic [NPORT-1:0]     rxbitout, rxvalid, collision, locked;
  logic [NPORT*FKW-1:0] cur_fk;

  bt_air_chan #(
    .NPORT  (NPORT),
    .FKW    (FKW),
    .LAT    (LAT),
    .SETTLE (SETTLE)
  ) dut (
    .clk_6M     (clk_6M),
    .rstz       (rstz),
    .txen       (txen),
    .rxen       (rxen),
    .txbitin    (txbitin),
    .lc_fk      (lc_fk),
    .loadfreq_p (loadfreq_p),
    .err_inj_en (err_inj_en),
    .err_thresh (err_thresh),
    .rxbitout   (rxbitout),
    .rxvalid    (rxvalid),
    .collision  (collision),
    .cur_fk     (cur_fk),
    .locked     (locked)
  );

  always #5 clk_6M = ~clk_6M;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic set_fk(input int p, input logic [FKW-1:0] v);
    lc_fk[p*FKW +: FKW] = v;
  endtask

  function automatic logic [FKW-1:0] fk_of(input int p);
    return cur_fk[p*FKW +: FKW];
  endfunction

  // Reference LFSR: Galois x^16+x^14+x^13+x^11+1, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk_6M or negedge rstz) begin
    if (!rstz) m_lfsr <= 16'hACE1;
    else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [15:0] ref_rotl(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[14:0], r[15]};
    return r;
  endfunction

  typedef struct {
    logic [3:0] tx;
    logic [3:0] rx;
    logic [3:0] tb;
    logic [3:0] e_bit;
    logic [3:0] e_valid;
    logic [3:0] e_coll;
  } vec_t;

  vec_t vt [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic       sent, b, eflip;
    logic [15:0] th;
    int         flips, mism;
    logic       q [$];

    // Port map: 0,1,3 at fk=10, port 2 at fk=11.
    vt[0] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
    vt[1] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    vt[2] = '{4'b0001, 4'b1110, 4'b0001, 4'b1010, 4'b1010, 4'b0000};
    vt[3] = '{4'b1001, 4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0010};
    vt[4] = '{4'b0011, 4'b1010, 4'b0011, 4'b0000, 4'b0000, 4'b1000};
    vt[5] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vt[6] = '{4'b0100, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    vt[7] = '{4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
    vt[8] = '{4'b1000, 4'b0111, 4'b1000, 4'b0011, 4'b0011, 4'b0000};
    vt[9] = '{4'b0001, 4'b0010, 4'b1110, 4'b0000, 4'b0010, 4'b0000};

    txen = '0; rxen = '0; txbitin = '0; loadfreq_p = '0; lc_fk = '0;
    err_inj_en = 1'b0; err_thresh = 16'h0000;

    #2;
    chk("rst_locked", locked, 0);
    chk("rst_cur_fk", cur_fk, 0);
    chk("rst_rx", {rxbitout, rxvalid, collision}, 0);
    tick();
    rstz = 1'b1;

    // Reset in the middle of settling
    set_fk(0, 7'd5);
    loadfreq_p = 4'b0001;
    tick();
    loadfreq_p = '0;
    repeat (399) tick();
    chk("mid_settle_locked", locked[0], 0);
    chk("mid_settle_fk", fk_of(0), 5);
    #2 rstz = 1'b0;
    #1;
    chk("async_rst_fk", cur_fk, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_rx", {rxbitout, rxvalid, collision}, 0);
    tick();
    rstz = 1'b1;

    // Lock timing: port0 plain, port1 re-strobed at 500, port3 re-strobed
    // on the very edge its count would expire.
    set_fk(0, 7'd5); set_fk(1, 7'd20); set_fk(3, 7'd30);
    loadfreq_p = 4'b1011;
    tick();
    loadfreq_p = '0;
    for (int k = 1; k <= 1800; k++) begin
      if (k == 500) begin set_fk(1, 7'd21); loadfreq_p[1] = 1'b1; end
      if (k == 900) begin set_fk(3, 7'd31); loadfreq_p[3] = 1'b1; end
      tick();
      loadfreq_p = '0;
      if (k == 899)  chk("lock0_e899", locked[0], 0);
      if (k == 900)  chk("lock0_e900", locked[0], 1);
      if (k == 900)  chk("lock1_old_deadline", locked[1], 0);
      if (k == 900)  chk("lock3_strobe_wins", locked[3], 0);
      if (k == 1399) chk("lock1_e1399", locked[1], 0);
      if (k == 1400) chk("lock1_e1400", locked[1], 1);
      if (k == 1400) chk("fk1_restrobe", fk_of(1), 21);
      if (k == 1799) chk("lock3_e1799", locked[3], 0);
      if (k == 1800) chk("lock3_e1800", locked[3], 1);
    end

    // Tune for routing: 10,10,11,10
    set_fk(0, 7'd10); set_fk(1, 7'd10); set_fk(2, 7'd11); set_fk(3, 7'd10);
    loadfreq_p = 4'b1111;
    tick();
    loadfreq_p = '0;
    repeat (SETTLE) tick();
    chk("cfg_locked", locked, 4'b1111);
    chk("cfg_fk", cur_fk, {7'd10, 7'd11, 7'd10, 7'd10});

    for (int i = 0; i < 10; i++) begin
      txen = vt[i].tx; rxen = vt[i].rx; txbitin = vt[i].tb;
      repeat (LAT) tick();
      chk($sformatf("v%0d_bit", i), rxbitout, vt[i].e_bit);
      chk($sformatf("v%0d_valid", i), rxvalid, vt[i].e_valid);
      chk($sformatf("v%0d_coll", i), collision, vt[i].e_coll);
    end

    // Streaming 1011 port0 -> port1, exact LAT latency, in-flight bits
    // survive txen dropping.
    txen = '0; rxen = 4'b0110; txbitin = '0;
    repeat (LAT) tick();
    pat = 4'b1011;
    txen = 4'b0001;
    txbitin[0] = pat[3];
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t >= 3 && t <= 6) begin
        chk($sformatf("stream_bit%0d", t - 3), rxbitout[1], pat[6 - t]);
        chk($sformatf("stream_valid%0d", t - 3), rxvalid[1], 1);
      end
      if (t == 3) chk("stream_port2_valid", rxvalid[2], 0);
      if (t == 7) chk("stream_end_valid", rxvalid[1], 0);
      if (t < 4) txbitin[0] = pat[3 - t];
      else if (t == 4) txen = '0;
    end

    // Collision then recovery once port3 stops
    txen = 4'b1001; rxen = 4'b0010; txbitin = 4'b1001;
    repeat (LAT) tick();
    chk("coll_on", collision[1], 1);
    chk("coll_valid", rxvalid[1], 0);
    txen = 4'b0001;
    tick(); tick();
    chk("coll_inflight", collision[1], 1);
    tick();
    chk("coll_cleared", collision[1], 0);
    chk("coll_clean_bit", {rxvalid[1], rxbitout[1]}, 2'b11);

    // Error injection, port0 -> port1
    txen = 4'b0001; rxen = 4'b0010; err_inj_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      th = (pass == 0) ? 16'h0000 : 16'h8000;
      err_thresh = th;
      flips = 0; mism = 0;
      q.delete();
      for (int n = 0; n < 10000 + LAT - 1; n++) begin
        b = 1'($urandom_range(0, 1));
        txbitin[0] = b;
        tick();
        q.push_back(b);
        if (q.size() == LAT) begin
          sent  = q.pop_front();
          eflip = (ref_rotl(m_lfsr, 1) < th);
          if (rxvalid[1] !== 1'b1 || rxbitout[1] !== (sent ^ eflip)) mism++;
          if (rxbitout[1] !== sent) flips++;
        end
      end
      chk($sformatf("err_model_mism_th%0h", th), mism, 0);
      if (pass == 0) begin
        chk("err_flips_th0", flips, 0);
      end else begin
        checks++;
        if (flips < 4700 || flips > 5300) begin
          failures++;
          $display("FAIL err_flips_th8000 actual=%0d expected=4700..5300", flips);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
